systolic_job_controller: RTL and testbench

- Sequences one complete matrix-multiply job on the systolic array top level.
- Per job: resets both input queue write pointers, streams N*N north (column) words and then N*N west (row) words into the queue write ports, and pulses start.
- Waits for compute completion and then output-SRAM collection completion.
- Reads all N*N results out of the SRAM and presents them as a valid/ready result stream. Sits between a host/DMA stream source and the array.

---
 rtl/systolic_job_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_systolic_job_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_job_controller.sv
// Job sequencer for the systolic array: loads both operand queues, starts the
// multiply, waits for compute and collection, then streams the N*N results out.
module systolic_job_controller #(
    parameter int N              = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    output logic                   north_write_enable_o,
    output logic [DATA_WIDTH-1:0]  north_write_data_o,
    output logic                   north_write_reset_o,
    output logic                   west_write_enable_o,
    output logic [DATA_WIDTH-1:0]  west_write_data_o,
    output logic                   west_write_reset_o,
    output logic                   start_matrix_mult_o,
    input  logic                   matrix_mult_complete_i,
    input  logic                   collection_complete_i,
    output logic                   read_enable_o,
    output logic [$clog2(N*N)-1:0] read_addr_o,
    input  logic [DATA_WIDTH-1:0]  read_data_i,
    input  logic                   read_valid_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] LAST_IDX   = CW'(NN - 1);
    localparam logic [TW-1:0] TCNT_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        LOAD_N,
        LOAD_W,
        START,
        COMPUTE,
        COLLECT,
        RD_REQ,
        RD_WAIT,
        OUT_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_wcnt;
    logic [CW-1:0]         w_wcnt_next;
    logic [CW-1:0]         r_rcnt;
    logic [CW-1:0]         w_rcnt_next;
    logic [TW-1:0]         r_tcnt;
    logic [TW-1:0]         w_tcnt_next;
    logic [TW-1:0]         w_tcnt_inc;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] w_out_data_next;
    logic                  w_wcnt_last;
    logic                  w_rcnt_last;
    logic                  w_tcnt_expired;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_wcnt     <= '0;
            r_rcnt     <= '0;
            r_tcnt     <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wcnt     <= w_wcnt_next;
            r_rcnt     <= w_rcnt_next;
            r_tcnt     <= w_tcnt_next;
            r_out_data <= w_out_data_next;
        end
    end

    assign w_wcnt_last    = (r_wcnt == LAST_IDX);
    assign w_rcnt_last    = (r_rcnt == LAST_IDX);
    assign w_tcnt_expired = (r_tcnt == TCNT_LIMIT);
    // Saturate so the budget carries from COMPUTE into COLLECT without wrapping.
    assign w_tcnt_inc     = w_tcnt_expired ? r_tcnt : r_tcnt + TW'(1);

    assign out_data_o = r_out_data;
    assign busy_o     = (r_state != IDLE);

    always_comb begin
        w_state_next         = r_state;
        w_wcnt_next          = r_wcnt;
        w_rcnt_next          = r_rcnt;
        w_tcnt_next          = r_tcnt;
        w_out_data_next      = r_out_data;
        job_ready_o          = 1'b0;
        in_ready_o           = 1'b0;
        north_write_enable_o = 1'b0;
        north_write_data_o   = '0;
        north_write_reset_o  = 1'b0;
        west_write_enable_o  = 1'b0;
        west_write_data_o    = '0;
        west_write_reset_o   = 1'b0;
        start_matrix_mult_o  = 1'b0;
        read_enable_o        = 1'b0;
        read_addr_o          = '0;
        out_valid_o          = 1'b0;
        out_last_o           = 1'b0;
        timeout_o            = 1'b0;

        case (r_state)
            IDLE: begin
                job_ready_o = 1'b1;
                if (job_valid_i) begin
                    w_state_next = CLEAR;
                end
            end

            CLEAR: begin
                north_write_reset_o = 1'b1;
                west_write_reset_o  = 1'b1;
                w_wcnt_next         = '0;
                w_state_next        = LOAD_N;
            end

            LOAD_N: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    north_write_enable_o = 1'b1;
                    north_write_data_o   = in_data_i;
                    if (w_wcnt_last) begin
                        w_wcnt_next  = '0;
                        w_state_next = LOAD_W;
                    end else begin
                        w_wcnt_next = r_wcnt + CW'(1);
                    end
                end
            end

            LOAD_W: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    west_write_enable_o = 1'b1;
                    west_write_data_o   = in_data_i;
                    if (w_wcnt_last) begin
                        w_wcnt_next  = '0;
                        w_state_next = START;
                    end else begin
                        w_wcnt_next = r_wcnt + CW'(1);
                    end
                end
            end

            START: begin
                start_matrix_mult_o = 1'b1;
                w_tcnt_next         = '0;
                w_state_next        = COMPUTE;
            end

            // Exit condition is tested before the budget so a coincident
            // completion is never reported as a timeout.
            COMPUTE: begin
                if (matrix_mult_complete_i) begin
                    w_tcnt_next  = w_tcnt_inc;
                    w_state_next = COLLECT;
                end else if (w_tcnt_expired) begin
                    timeout_o    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_tcnt_next = w_tcnt_inc;
                end
            end

            COLLECT: begin
                if (collection_complete_i) begin
                    w_rcnt_next  = '0;
                    w_state_next = RD_REQ;
                end else if (w_tcnt_expired) begin
                    timeout_o    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_tcnt_next = w_tcnt_inc;
                end
            end

            RD_REQ: begin
                read_enable_o = 1'b1;
                read_addr_o   = r_rcnt[AW-1:0];
                w_state_next  = RD_WAIT;
            end

            // A missing read_valid_i is a fabric fault; we deliberately wait.
            RD_WAIT: begin
                if (read_valid_i) begin
                    w_out_data_next = read_data_i;
                    w_state_next    = OUT_HOLD;
                end
            end

            OUT_HOLD: begin
                out_valid_o = 1'b1;
                out_last_o  = w_rcnt_last;
                if (out_ready_i) begin
                    if (w_rcnt_last) begin
                        w_state_next = IDLE;
                    end else begin
                        w_rcnt_next  = r_rcnt + CW'(1);
                        w_state_next = RD_REQ;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_job_controller.sv
// Directed bench for systolic_job_controller with N=2 and a short timeout,
// including a small array/SRAM model behind the controller.
module tb_systolic_job_controller;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int NN = N * N;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          job_valid_i;
    logic          job_ready_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i;
    logic          north_write_enable_o;
    logic [DW-1:0] north_write_data_o;
    logic          north_write_reset_o;
    logic          west_write_enable_o;
    logic [DW-1:0] west_write_data_o;
    logic          west_write_reset_o;
    logic          start_matrix_mult_o;
    logic          matrix_mult_complete_i;
    logic          collection_complete_i;
    logic          read_enable_o;
    logic [1:0]    read_addr_o;
    logic [DW-1:0] read_data_i;
    logic          read_valid_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          busy_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    systolic_job_controller #(
        .N              (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i                  (clk_i),
        .rstn_i                 (rstn_i),
        .job_valid_i            (job_valid_i),
        .job_ready_o            (job_ready_o),
        .in_valid_i             (in_valid_i),
        .in_ready_o             (in_ready_o),
        .in_data_i              (in_data_i),
        .north_write_enable_o   (north_write_enable_o),
        .north_write_data_o     (north_write_data_o),
        .north_write_reset_o    (north_write_reset_o),
        .west_write_enable_o    (west_write_enable_o),
        .west_write_data_o      (west_write_data_o),
        .west_write_reset_o     (west_write_reset_o),
        .start_matrix_mult_o    (start_matrix_mult_o),
        .matrix_mult_complete_i (matrix_mult_complete_i),
        .collection_complete_i  (collection_complete_i),
        .read_enable_o          (read_enable_o),
        .read_addr_o            (read_addr_o),
        .read_data_i            (read_data_i),
        .read_valid_i           (read_valid_i),
        .out_valid_o            (out_valid_o),
        .out_ready_i            (out_ready_i),
        .out_data_o             (out_data_o),
        .out_last_o             (out_last_o),
        .busy_o                 (busy_o),
        .timeout_o              (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Array model: compute done 10 cycles after start, collection 6 later.
    bit model_en;
    bit model_run;
    int since;
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            model_run <= 1'b0;
            since     <= 0;
        end else if (start_matrix_mult_o) begin
            model_run <= 1'b1;
            since     <= 1;
        end else if (model_run && since < 1000) begin
            since <= since + 1;
        end
    end
    assign matrix_mult_complete_i = model_en && model_run && (since >= 10);
    assign collection_complete_i  = model_en && model_run && (since >= 16);

    // Output SRAM model: one-cycle read latency, data = addr*10.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            read_valid_i <= 1'b0;
            read_data_i  <= '0;
        end else begin
            read_valid_i <= read_enable_o;
            read_data_i  <= read_enable_o ? 32'(read_addr_o) * 32'd10 : 32'd0;
        end
    end

    // Event recorder, sampled mid-low-phase once inputs have settled.
    logic [DW-1:0] north_q[$];
    logic [DW-1:0] west_q[$];
    logic [DW-1:0] out_q[$];
    logic          last_q[$];
    int            addr_q[$];
    int n_wrst  = 0;
    int n_start = 0;
    int n_tmo   = 0;
    int n_outv  = 0;
    always @(negedge clk_i) begin
        #3;
        if (north_write_enable_o) north_q.push_back(north_write_data_o);
        if (west_write_enable_o)  west_q.push_back(west_write_data_o);
        if (north_write_reset_o && west_write_reset_o) n_wrst++;
        if (start_matrix_mult_o) n_start++;
        if (timeout_o) n_tmo++;
        if (read_enable_o) addr_q.push_back(int'(read_addr_o));
        if (out_valid_o) n_outv++;
        if (out_valid_o && out_ready_i) begin
            out_q.push_back(out_data_o);
            last_q.push_back(out_last_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Request a job and check the single CLEAR cycle.
    task automatic begin_job();
        @(negedge clk_i);
        job_valid_i = 1'b1;
        #1;
        chk("idle_job_ready", job_ready_o, 1);
        @(negedge clk_i);
        job_valid_i = 1'b0;
        #1;
        chk("clear_north_rst", north_write_reset_o, 1);
        chk("clear_west_rst", west_write_reset_o, 1);
        chk("clear_in_ready", in_ready_o, 0);
    endtask

    // Push 2*NN words first..first+2NN-1, optionally with bubbles, then check start.
    task automatic load_words(input int first, input bit bubbles);
        int hs = 0;
        int cyc = 0;
        while (hs < 2 * NN && cyc < 100) begin
            @(negedge clk_i);
            in_valid_i = bubbles ? cyc[0] == 1'b0 : 1'b1;
            in_data_i  = in_valid_i ? 32'(first + hs) : 32'hDEAD_BEEF;
            #1;
            if (in_valid_i && in_ready_o) hs++;
            cyc++;
        end
        chk("load_handshakes", hs, 2 * NN);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        chk("start_after_last", start_matrix_mult_o, 1);
        chk("start_in_ready", in_ready_o, 0);
    endtask

    // Accept results until idle; optionally stall word 1 for 5 cycles.
    task automatic drain(input bit backpressure);
        int acc = 0;
        int held = 0;
        int cyc = 0;
        while (busy_o && cyc < 300) begin
            if (backpressure && out_valid_o && acc == 1 && held < 5) begin
                out_ready_i = 1'b0;
                held++;
                chk("bp_hold_data", out_data_o, 10);
                chk("bp_no_read", read_enable_o, 0);
            end else begin
                out_ready_i = 1'b1;
                if (out_valid_o) acc++;
            end
            @(negedge clk_i);
            #1;
            cyc++;
        end
        out_ready_i = 1'b0;
        chk("drain_idle", busy_o, 0);
        if (backpressure) chk("bp_stall_cycles", held, 5);
    endtask

    task automatic check_results(input int ob, input int ab, input int nb, input int wb,
                                 input int first);
        chk("north_count", north_q.size() - nb, NN);
        chk("west_count", west_q.size() - wb, NN);
        for (int k = 0; k < NN; k++) begin
            chk("north_word", north_q[nb + k], 32'(first + k));
            chk("west_word", west_q[wb + k], 32'(first + NN + k));
        end
        chk("out_count", out_q.size() - ob, NN);
        chk("addr_count", addr_q.size() - ab, NN);
        for (int k = 0; k < NN; k++) begin
            chk("out_word", out_q[ob + k], 32'(k * 10));
            chk("out_last", last_q[ob + k], (k == NN - 1) ? 1 : 0);
            chk("read_addr", addr_q[ab + k], k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, ab, nb, wb, st, tb0, tmo_at, outv0;
        rstn_i      = 1'b0;
        job_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        model_en    = 1'b1;

        // Reset values
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_job_ready", job_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_start", start_matrix_mult_o, 0);
        chk("rst_read_en", read_enable_o, 0);
        chk("rst_timeout", timeout_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Job 1: contiguous words 1..8; completion coincides with timeout limit
        ob = out_q.size(); ab = addr_q.size(); nb = north_q.size(); wb = west_q.size();
        st = n_start; tb0 = n_tmo;
        begin_job();
        load_words(1, 1'b0);
        drain(1'b0);
        check_results(ob, ab, nb, wb, 1);
        chk("job1_starts", n_start - st, 1);
        chk("job1_no_timeout", n_tmo - tb0, 0);
        chk("job1_wrst_cycles", n_wrst, 1);

        // Job 2: input bubbles and output backpressure on word 1
        ob = out_q.size(); ab = addr_q.size(); nb = north_q.size(); wb = west_q.size();
        st = n_start;
        begin_job();
        load_words(1, 1'b1);
        drain(1'b1);
        check_results(ob, ab, nb, wb, 1);
        chk("job2_starts", n_start - st, 1);

        // Job 3: compute never completes -> timeout 16 cycles after start
        model_en = 1'b0;
        ab = addr_q.size(); tb0 = n_tmo; outv0 = n_outv;
        begin_job();
        load_words(21, 1'b0);
        tmo_at = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            #1;
            if (timeout_o && tmo_at < 0) tmo_at = c;
        end
        chk("tmo_cycle", tmo_at, 16);
        chk("tmo_pulses", n_tmo - tb0, 1);
        chk("tmo_idle", busy_o, 0);
        chk("tmo_job_ready", job_ready_o, 1);
        chk("tmo_no_out_valid", n_outv - outv0, 0);
        chk("tmo_no_reads", addr_q.size() - ab, 0);
        model_en = 1'b1;

        // Job 4: asynchronous reset after two west writes
        nb = north_q.size(); wb = west_q.size();
        begin_job();
        for (int i = 0; i < NN + 2; i++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            in_data_i  = 32'(101 + i);
        end
        @(negedge clk_i);
        rstn_i    = 1'b0;
        in_data_i = 32'd999;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_job_ready", job_ready_o, 1);
        chk("mid_rst_in_ready", in_ready_o, 0);
        chk("mid_rst_west_we", west_write_enable_o, 0);
        chk("mid_rst_west_data", west_write_data_o, 0);
        chk("mid_rst_out_data", out_data_o, 0);
        chk("mid_rst_north_w", north_q.size() - nb, NN);
        chk("mid_rst_west_w", west_q.size() - wb, 2);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Job 5: fresh job after reset runs normally
        ob = out_q.size(); ab = addr_q.size(); nb = north_q.size(); wb = west_q.size();
        st = n_start;
        begin_job();
        load_words(11, 1'b0);
        drain(1'b0);
        check_results(ob, ab, nb, wb, 11);
        chk("job5_starts", n_start - st, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
